// File: rtl/ram_pkg.sv
// Shared types and defaults for the byte-enabled synchronous RAM and its clear sequencer.
package ram_pkg;

    localparam int DEF_ADDR_SIZE   = 4;
    localparam int DEF_WORD_SIZE   = 16;
    localparam int DEF_MEMORY_SIZE = 16;
    localparam int DEF_CLR_VALUE   = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

    function automatic int lane_count(input int word_size);
        return word_size / 8;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear engine: walks every word after reset or on request, and owns the array write port mux.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int                   ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int                   WORD_SIZE   = DEF_WORD_SIZE,
    parameter int                   MEMORY_SIZE = DEF_MEMORY_SIZE,
    parameter logic [WORD_SIZE-1:0] CLR_VALUE   = WORD_SIZE'(DEF_CLR_VALUE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             user_we,
    input  logic [ADDR_SIZE-1:0]             user_addr,
    input  logic [WORD_SIZE-1:0]             user_data,
    input  logic [lane_count(WORD_SIZE)-1:0] user_be,
    output logic                             busy,
    output logic                             mem_we,
    output logic [ADDR_SIZE-1:0]             mem_addr,
    output logic [WORD_SIZE-1:0]             mem_data,
    output logic [lane_count(WORD_SIZE)-1:0] mem_be
);

    // One extra pointer bit so a full 2^ADDR_SIZE array ends without wrapping to 0.
    localparam logic [ADDR_SIZE:0] LAST_PTR = (ADDR_SIZE + 1)'(MEMORY_SIZE - 1);

    ram_state_t           state;
    logic [ADDR_SIZE:0]   clr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    // NOTE: every output gets a default first so the mux cannot infer a latch.
    always_comb begin
        mem_we   = user_we;
        mem_addr = user_addr;
        mem_data = user_data;
        mem_be   = user_be;
        if (state == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_ptr[ADDR_SIZE-1:0];
            mem_data = CLR_VALUE;
            mem_be   = '1;
        end
    end

endmodule

// File: rtl/ram_sync_bwe.sv
// Synchronous RAM with per-byte write enables, registered write-first read and a hardware clear engine.
module ram_sync_bwe
    import ram_pkg::*;
#(
    parameter int                   ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int                   WORD_SIZE   = DEF_WORD_SIZE,
    parameter int                   MEMORY_SIZE = DEF_MEMORY_SIZE,
    parameter logic [WORD_SIZE-1:0] CLR_VALUE   = WORD_SIZE'(DEF_CLR_VALUE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cs,
    input  logic                             wr,
    input  logic [ADDR_SIZE-1:0]             wr_addr,
    input  logic [WORD_SIZE-1:0]             data_in,
    input  logic [lane_count(WORD_SIZE)-1:0] be,
    input  logic                             rd,
    input  logic [ADDR_SIZE-1:0]             rd_addr,
    input  logic                             clr,
    output logic [WORD_SIZE-1:0]             data_out,
    output logic                             rd_valid,
    output logic                             addr_err,
    output logic                             busy
);

    localparam int                 LANES     = lane_count(WORD_SIZE);
    localparam logic [ADDR_SIZE:0] MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);

    logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

    logic                 access_ok;
    logic                 wr_req;
    logic                 rd_req;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 wr_en;
    logic [WORD_SIZE-1:0] rd_word;

    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data;
    logic [LANES-1:0]     mem_be;

    // A clr request takes priority over any access presented in the same cycle.
    assign access_ok   = cs & ~busy & ~clr;
    assign wr_req      = access_ok & wr;
    assign rd_req      = access_ok & rd;
    assign wr_in_range = ({1'b0, wr_addr} < MEM_LIMIT);
    assign rd_in_range = ({1'b0, rd_addr} < MEM_LIMIT);
    assign wr_en       = wr_req & wr_in_range;

    ram_clr_seq #(
        .ADDR_SIZE  (ADDR_SIZE),
        .WORD_SIZE  (WORD_SIZE),
        .MEMORY_SIZE(MEMORY_SIZE),
        .CLR_VALUE  (CLR_VALUE)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .user_we  (wr_en),
        .user_addr(wr_addr),
        .user_data(data_in),
        .user_be  (be),
        .busy     (busy),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_be   (mem_be)
    );

    // NOTE: the array has no reset so it maps onto RAM macros; the clear engine initialises it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
            end
        end
    end

    // Write-first: a same-address write this cycle overrides the enabled lanes of the stored word.
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) rd_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            addr_err <= (rd_req & ~rd_in_range) | (wr_req & ~wr_in_range);
            if (rd_req) data_out <= rd_in_range ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_ram_sync_bwe.sv
// Bench for ram_sync_bwe: a full-size and a 12-word instance share stimulus and are checked against a behavioural model.
module tb_ram_sync_bwe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [3:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] data_in = '0;
    logic [1:0]  be = '0;

    logic [15:0] d16, d12;
    logic        v16, v12, e16, e12, b16, b12;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ram_sync_bwe #(.ADDR_SIZE(4), .WORD_SIZE(16), .MEMORY_SIZE(16), .CLR_VALUE(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .wr_addr(wr_addr), .data_in(data_in),
        .be(be), .rd(rd), .rd_addr(rd_addr), .clr(clr),
        .data_out(d16), .rd_valid(v16), .addr_err(e16), .busy(b16)
    );

    ram_sync_bwe #(.ADDR_SIZE(4), .WORD_SIZE(16), .MEMORY_SIZE(12), .CLR_VALUE(16'h5A5A)) dut12 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .wr_addr(wr_addr), .data_in(data_in),
        .be(be), .rd(rd), .rd_addr(rd_addr), .clr(clr),
        .data_out(d12), .rd_valid(v12), .addr_err(e12), .busy(b12)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clear remaining-cycle counter, word array, expected outputs.
    int          mdl_size [2] = '{16, 12};
    logic [15:0] mdl_clr  [2] = '{16'h0000, 16'h5A5A};
    logic [15:0] mdl_mem  [2][16];
    int          clr_left [2];
    logic [15:0] x_dout   [2];
    logic        x_val    [2];
    logic        x_err    [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                clr_left[k] = mdl_size[k];
                x_dout[k]   = '0;
                x_val[k]    = 1'b0;
                x_err[k]    = 1'b0;
            end else if (clr_left[k] > 0) begin
                x_val[k] = 1'b0;
                x_err[k] = 1'b0;
                clr_left[k]--;
                if (clr_left[k] == 0)
                    for (int a = 0; a < mdl_size[k]; a++) mdl_mem[k][a] = mdl_clr[k];
            end else if (clr) begin
                x_val[k]    = 1'b0;
                x_err[k]    = 1'b0;
                clr_left[k] = mdl_size[k];
            end else begin
                x_err[k] = 1'b0;
                if (cs && wr) begin
                    if (int'(wr_addr) < mdl_size[k]) begin
                        for (int b = 0; b < 2; b++)
                            if (be[b]) mdl_mem[k][wr_addr][8*b +: 8] = data_in[8*b +: 8];
                    end else begin
                        x_err[k] = 1'b1;
                    end
                end
                x_val[k] = cs && rd;
                if (cs && rd) begin
                    if (int'(rd_addr) < mdl_size[k]) begin
                        x_dout[k] = mdl_mem[k][rd_addr];
                    end else begin
                        x_dout[k] = '0;
                        x_err[k]  = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy16", b16, clr_left[0] > 0);
            check("cmp_valid16", v16, x_val[0]);
            check("cmp_err16", e16, x_err[0]);
            check("cmp_dout16", d16, x_dout[0]);
            check("cmp_busy12", b12, clr_left[1] > 0);
            check("cmp_valid12", v12, x_val[1]);
            check("cmp_err12", e12, x_err[1]);
            check("cmp_dout12", d12, x_dout[1]);
        end
    end

    task automatic step(input logic c, input logic w, input logic [3:0] wa, input logic [15:0] di,
                        input logic [1:0] b, input logic r, input logic [3:0] ra, input logic cl);
        @(negedge clk);
        cs = c; wr = w; wr_addr = wa; data_in = di; be = b; rd = r; rd_addr = ra; clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_op(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        step(1'b1, 1'b1, a, d, b, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd_op(input logic [3:0] a);
        step(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, a, 1'b0);
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0);
    endtask

    // Counts busy cycles of both instances (bounded); optionally releases clr after a few cycles.
    task automatic count_busy(output int n16, output int n12, output int nv);
        n16 = 0; n12 = 0; nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (b16) n16++;
            if (b12) n12++;
            if (b16 && v16) nv++;
            if (i == 3) clr = 1'b0;
            if (!b16 && !b12) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_all_zero16(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_op(4'(a));
            check({tag, "_dout16"}, d16, 16'h0000);
            check({tag, "_valid16"}, v16, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n16, n12, nv;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_dout16", d16, 16'h0000);
        check("reset_valid16", v16, 1'b0);
        check("reset_err16", e16, 1'b0);
        check("reset_busy16", b16, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_busy(n16, n12, nv);
        check("init_busy_cycles16", n16, 16);
        check("init_busy_cycles12", n12, 12);
        read_all_zero16("init_read");

        wr_op(4'd3, 16'hA5C3, 2'b11);
        wr_op(4'd3, 16'h00FF, 2'b01);
        rd_op(4'd3);
        check("merge_dout16", d16, 16'hA5FF);
        check("merge_model16", x_dout[0], 16'hA5FF);
        check("merge_valid16", v16, 1'b1);
        nop();
        check("hold_valid16", v16, 1'b0);
        check("hold_dout16", d16, 16'hA5FF);

        wr_op(4'd7, 16'hBEEF, 2'b11);
        step(1'b1, 1'b1, 4'd7, 16'h1234, 2'b10, 1'b1, 4'd7, 1'b0);
        check("bypass_dout16", d16, 16'h12EF);
        check("bypass_dout12", d12, 16'h12EF);

        wr_op(4'd3, 16'h0000, 2'b00);
        check("be0_err16", e16, 1'b0);
        rd_op(4'd3);
        check("be0_dout16", d16, 16'hA5FF);

        wr_op(4'd13, 16'h5555, 2'b11);
        check("oob_wr_err12", e12, 1'b1);
        check("oob_wr_err16", e16, 1'b0);
        rd_op(4'd13);
        check("oob_rd_dout12", d12, 16'h0000);
        check("oob_rd_err12", e12, 1'b1);
        check("oob_rd_valid12", v12, 1'b1);
        check("inrange_rd_dout16", d16, 16'h5555);
        step(1'b1, 1'b1, 4'd12, 16'h7777, 2'b11, 1'b1, 4'd11, 1'b0);
        check("edge_err12", e12, 1'b1);
        check("edge_dout12", d12, 16'h5A5A);
        nop();
        check("err_clears12", e12, 1'b0);

        for (int a = 0; a < 16; a++) wr_op(4'(a), 16'hFFFF, 2'b11);
        rd_op(4'd5);
        check("fill_dout16", d16, 16'hFFFF);
        step(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1);
        count_busy(n16, n12, nv);
        check("clr_busy_cycles16", n16, 16);
        check("clr_busy_cycles12", n12, 12);
        check("clr_rd_valid_while_busy", nv, 0);
        read_all_zero16("clr_read");

        wr_op(4'd2, 16'hC0DE, 2'b11);
        rd_op(4'd2);
        check("pre_rst_dout16", d16, 16'hC0DE);
        step(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1);
        clr = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("async_dout16", d16, 16'h0000);
        check("async_dout12", d12, 16'h0000);
        check("async_busy16", b16, 1'b1);
        check("async_valid16", v16, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_busy(n16, n12, nv);
        check("rst_busy_cycles16", n16, 16);
        check("rst_busy_cycles12", n12, 12);
        read_all_zero16("rst_read");
        nop();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
